vx_mem_bus_arbiter: RTL and testbench

VX_MEM_BUS_ARBITER -- requirements
Module: vx_mem_bus_arbiter

---
 rtl/vx_mem_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_vx_mem_bus_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_bus_arbiter.sv
// Round-robin arbiter that merges NUM_REQS memory request buses onto one bus.
// Requests pass through a 2-entry FIFO; responses are routed back by tag LSBs.
module vx_mem_bus_arbiter #(
    parameter int NUM_REQS    = 4,
    parameter int DATA_SIZE   = 64,
    parameter int ADDR_WIDTH  = 26,
    parameter int FLAGS_WIDTH = 4,
    parameter int TAG_WIDTH   = 8,
    localparam int LOG_N         = $clog2(NUM_REQS),
    localparam int OUT_TAG_WIDTH = TAG_WIDTH + LOG_N
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic [NUM_REQS-1:0]                 in_req_valid,
    output logic [NUM_REQS-1:0]                 in_req_ready,
    input  logic [NUM_REQS-1:0]                 in_req_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]      in_req_addr,
    input  logic [NUM_REQS*DATA_SIZE*8-1:0]     in_req_data,
    input  logic [NUM_REQS*DATA_SIZE-1:0]       in_req_byteen,
    input  logic [NUM_REQS*FLAGS_WIDTH-1:0]     in_req_flags,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]       in_req_tag,

    output logic [NUM_REQS-1:0]                 in_rsp_valid,
    output logic [NUM_REQS*DATA_SIZE*8-1:0]     in_rsp_data,
    output logic [NUM_REQS*TAG_WIDTH-1:0]       in_rsp_tag,
    input  logic [NUM_REQS-1:0]                 in_rsp_ready,

    output logic                                out_req_valid,
    input  logic                                out_req_ready,
    output logic                                out_req_rw,
    output logic [ADDR_WIDTH-1:0]               out_req_addr,
    output logic [DATA_SIZE*8-1:0]              out_req_data,
    output logic [DATA_SIZE-1:0]                out_req_byteen,
    output logic [FLAGS_WIDTH-1:0]              out_req_flags,
    output logic [OUT_TAG_WIDTH-1:0]            out_req_tag,

    input  logic                                out_rsp_valid,
    input  logic [DATA_SIZE*8-1:0]              out_rsp_data,
    input  logic [OUT_TAG_WIDTH-1:0]            out_rsp_tag,
    output logic                                out_rsp_ready
);

    localparam int DW      = DATA_SIZE * 8;
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DW + DATA_SIZE + FLAGS_WIDTH + OUT_TAG_WIDTH;

    logic [LOG_N-1:0]   rr_ptr_q, rr_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [ENTRY_W-1:0] mem_q [2];

    logic               found_hi, found_lo;
    logic [LOG_N-1:0]   win_hi, win_lo, winner;
    logic               grant, pop;
    logic [ENTRY_W-1:0] push_entry;
    logic               rsp_hit;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (in_req_valid[i]) begin
                found_lo = 1'b1;
                win_lo   = LOG_N'(i);
                if (LOG_N'(i) >= rr_ptr_q) begin
                    found_hi = 1'b1;
                    win_hi   = LOG_N'(i);
                end
            end
        end
    end

    assign winner = found_hi ? win_hi : win_lo;
    assign pop    = (count_q != 2'd0) && out_req_ready;
    assign grant  = !reset && found_lo && ((count_q != 2'd2) || out_req_ready);

    always_comb begin
        in_req_ready = '0;
        push_entry   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (winner == LOG_N'(i)) begin
                in_req_ready[i] = grant;
                push_entry = {in_req_rw[i],
                              in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                              in_req_data[i*DW +: DW],
                              in_req_byteen[i*DATA_SIZE +: DATA_SIZE],
                              in_req_flags[i*FLAGS_WIDTH +: FLAGS_WIDTH],
                              in_req_tag[i*TAG_WIDTH +: TAG_WIDTH],
                              LOG_N'(i)};
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (winner == LOG_N'(NUM_REQS - 1)) ? '0 : winner + LOG_N'(1);
        end
        count_d  = count_q + {1'b0, grant} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ grant;
        rd_ptr_d = rd_ptr_q ^ pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // When full, a push lands in the slot being popped this same cycle.
    always_ff @(posedge clk) begin
        if (grant) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign out_req_valid = (count_q != 2'd0);
    assign {out_req_rw, out_req_addr, out_req_data, out_req_byteen,
            out_req_flags, out_req_tag} = mem_q[rd_ptr_q];

    // An unmapped index is dropped: nothing is raised and the response is consumed.
    always_comb begin
        rsp_hit       = 1'b0;
        in_rsp_valid  = '0;
        out_rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (out_rsp_tag[LOG_N-1:0] == LOG_N'(i)) begin
                rsp_hit         = 1'b1;
                in_rsp_valid[i] = out_rsp_valid;
                out_rsp_ready   = in_rsp_ready[i];
            end
        end
    end

    assign in_rsp_data = {NUM_REQS{out_rsp_data}};
    assign in_rsp_tag  = {NUM_REQS{out_rsp_tag[OUT_TAG_WIDTH-1:LOG_N]}};

    rsp_sel_legal: assert property (@(posedge clk) disable iff (reset) out_rsp_valid |-> rsp_hit);

endmodule

// File: tb/tb_vx_mem_bus_arbiter.sv
// Bench for vx_mem_bus_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vx_mem_bus_arbiter;

    localparam int N     = 4;
    localparam int DS    = 64;
    localparam int AW    = 26;
    localparam int FW    = 4;
    localparam int TW    = 8;
    localparam int LOG_N = 2;
    localparam int OTW   = TW + LOG_N;
    localparam int DW    = DS * 8;

    logic clk = 1'b0;
    logic reset;

    logic [N-1:0]    in_req_valid, in_req_ready, in_req_rw;
    logic [N*AW-1:0] in_req_addr;
    logic [N*DW-1:0] in_req_data;
    logic [N*DS-1:0] in_req_byteen;
    logic [N*FW-1:0] in_req_flags;
    logic [N*TW-1:0] in_req_tag;
    logic [N-1:0]    in_rsp_valid, in_rsp_ready;
    logic [N*DW-1:0] in_rsp_data;
    logic [N*TW-1:0] in_rsp_tag;
    logic            out_req_valid, out_req_ready, out_req_rw;
    logic [AW-1:0]   out_req_addr;
    logic [DW-1:0]   out_req_data;
    logic [DS-1:0]   out_req_byteen;
    logic [FW-1:0]   out_req_flags;
    logic [OTW-1:0]  out_req_tag;
    logic            out_rsp_valid, out_rsp_ready;
    logic [DW-1:0]   out_rsp_data;
    logic [OTW-1:0]  out_rsp_tag;

    typedef struct packed {
        logic           rw;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [DS-1:0]  be;
        logic [FW-1:0]  flags;
        logic [OTW-1:0] tag;
    } req_t;

    req_t q[$];
    int   rr;
    int   total = 0;
    int   bad   = 0;

    logic          r_rw    [N];
    logic [AW-1:0] r_addr  [N];
    logic [DW-1:0] r_data  [N];
    logic [DS-1:0] r_be    [N];
    logic [FW-1:0] r_flags [N];
    logic [TW-1:0] r_tag   [N];

    logic [N-1:0] g_seq [5];
    int           l_seq [5];

    always #5 clk = ~clk;

    vx_mem_bus_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .in_req_valid   (in_req_valid),
        .in_req_ready   (in_req_ready),
        .in_req_rw      (in_req_rw),
        .in_req_addr    (in_req_addr),
        .in_req_data    (in_req_data),
        .in_req_byteen  (in_req_byteen),
        .in_req_flags   (in_req_flags),
        .in_req_tag     (in_req_tag),
        .in_rsp_valid   (in_rsp_valid),
        .in_rsp_data    (in_rsp_data),
        .in_rsp_tag     (in_rsp_tag),
        .in_rsp_ready   (in_rsp_ready),
        .out_req_valid  (out_req_valid),
        .out_req_ready  (out_req_ready),
        .out_req_rw     (out_req_rw),
        .out_req_addr   (out_req_addr),
        .out_req_data   (out_req_data),
        .out_req_byteen (out_req_byteen),
        .out_req_flags  (out_req_flags),
        .out_req_tag    (out_req_tag),
        .out_rsp_valid  (out_rsp_valid),
        .out_rsp_data   (out_rsp_data),
        .out_rsp_tag    (out_rsp_tag),
        .out_rsp_ready  (out_rsp_ready)
    );

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int model_winner(logic [N-1:0] v, int ptr);
        for (int k = 0; k < N; k++) begin
            int idx = (ptr + k) % N;
            if (((v >> idx) & N'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    function automatic req_t make_entry(int w);
        req_t e;
        e.rw    = r_rw[w];
        e.addr  = r_addr[w];
        e.data  = r_data[w];
        e.be    = r_be[w];
        e.flags = r_flags[w];
        e.tag   = {r_tag[w], LOG_N'(w)};
        return e;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            r_rw[i]    = 1'($urandom());
            r_addr[i]  = AW'($urandom());
            for (int j = 0; j < DW / 32; j++) r_data[i][j*32 +: 32] = $urandom();
            r_be[i]    = {$urandom(), $urandom()};
            r_flags[i] = FW'($urandom());
            r_tag[i]   = TW'($urandom());
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            in_req_rw[i]                 = r_rw[i];
            in_req_addr[i*AW +: AW]      = r_addr[i];
            in_req_data[i*DW +: DW]      = r_data[i];
            in_req_byteen[i*DS +: DS]    = r_be[i];
            in_req_flags[i*FW +: FW]     = r_flags[i];
            in_req_tag[i*TW +: TW]       = r_tag[i];
        end
    endtask

    // Called just after the falling edge: drive, settle, compare against the model.
    task automatic compare();
        logic [N-1:0] exp_rdy;
        int w;
        int sel;
        pack();
        #1;
        if (reset) begin
            q.delete();
            rr = 0;
        end
        w = model_winner(in_req_valid, rr);
        exp_rdy = '0;
        if (!reset && w >= 0 && (q.size() < 2 || out_req_ready)) exp_rdy = N'(1) << w;
        chk("in_req_ready", in_req_ready, exp_rdy);
        chk("out_req_valid", out_req_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_req_rw", out_req_rw, q[0].rw);
            chk("out_req_addr", out_req_addr, q[0].addr);
            chk("out_req_data", out_req_data, q[0].data);
            chk("out_req_byteen", out_req_byteen, q[0].be);
            chk("out_req_flags", out_req_flags, q[0].flags);
            chk("out_req_tag", out_req_tag, q[0].tag);
        end
        sel = int'(out_rsp_tag) % N;
        chk("in_rsp_valid", in_rsp_valid, out_rsp_valid ? N'(1) << sel : N'(0));
        chk("out_rsp_ready", out_rsp_ready, 1'(in_rsp_ready >> sel));
        for (int i = 0; i < N; i++) begin
            chk("in_rsp_data", in_rsp_data[i*DW +: DW], out_rsp_data);
            chk("in_rsp_tag", in_rsp_tag[i*TW +: TW], out_rsp_tag >> LOG_N);
        end
    endtask

    task automatic advance();
        int   w;
        bit   pop;
        bit   grant;
        req_t e;
        w     = model_winner(in_req_valid, rr);
        pop   = !reset && q.size() > 0 && out_req_ready;
        grant = !reset && w >= 0 && (q.size() < 2 || out_req_ready);
        if (grant) e = make_entry(w);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (grant) begin
            q.push_back(e);
            rr = (w + 1) % N;
        end
        @(negedge clk);
    endtask

    initial begin
        g_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        l_seq = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        in_req_valid  = '0;
        out_req_ready = 1'b0;
        out_rsp_valid = 1'b0;
        out_rsp_tag   = '0;
        out_rsp_data  = '0;
        in_rsp_ready  = '0;
        rr = 0;
        rand_fields();

        @(negedge clk);
        compare();
        chk("rst_in_req_ready", in_req_ready, 0);
        chk("rst_out_req_valid", out_req_valid, 0);
        advance();
        reset = 1'b0;

        // All requesters valid: strict rotation, one request per cycle.
        in_req_valid  = 4'b1111;
        out_req_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            compare();
            if (c < 5) chk("rr_grant", in_req_ready, g_seq[c]);
            if (c >= 1) begin
                chk("rr_out_valid", out_req_valid, 1);
                chk("rr_tag_lsb", out_req_tag[LOG_N-1:0], l_seq[c-1]);
            end
            advance();
        end

        // Single requester 2 with tag 0x5A.
        in_req_valid = 4'b0100;
        r_tag[2]     = 8'h5A;
        compare();
        chk("solo_grant", in_req_ready, 4'b0100);
        advance();
        in_req_valid = 4'b0000;
        compare();
        chk("solo_valid", out_req_valid, 1);
        chk("solo_tag", out_req_tag, 10'h16A);
        advance();
        in_req_valid = 4'b1111;
        compare();
        chk("solo_rr_next", in_req_ready, 4'b1000);
        advance();
        in_req_valid = 4'b0000;
        repeat (3) begin
            compare();
            advance();
        end

        // Back-pressure: two accepted, then stall; drains in order.
        out_req_ready = 1'b0;
        in_req_valid  = 4'b0011;
        r_tag[0]      = 8'h11;
        r_tag[1]      = 8'h22;
        compare();
        chk("bp_grant0", in_req_ready, 4'b0001);
        advance();
        compare();
        chk("bp_grant1", in_req_ready, 4'b0010);
        chk("bp_head0", out_req_tag, 10'h044);
        advance();
        out_rsp_valid = 1'b1;
        out_rsp_tag   = 10'h2F3;
        in_rsp_ready  = 4'b0111;
        compare();
        chk("bp_full", in_req_ready, 4'b0000);
        chk("bp_hold", out_req_tag, 10'h044);
        chk("rsp_valid_lit", in_rsp_valid, 4'b1000);
        chk("rsp_tag_lit", in_rsp_tag[3*TW +: TW], 8'hBC);
        chk("rsp_ready_lit", out_rsp_ready, 0);
        advance();
        out_rsp_valid = 1'b0;
        out_req_ready = 1'b1;
        in_req_valid  = 4'b0000;
        compare();
        chk("drain0", out_req_tag, 10'h044);
        advance();
        compare();
        chk("drain1", out_req_tag, 10'h089);
        advance();
        compare();
        chk("drain_empty", out_req_valid, 0);
        advance();

        // Reset with a full FIFO.
        out_req_ready = 1'b0;
        in_req_valid  = 4'b0011;
        compare();
        advance();
        compare();
        advance();
        compare();
        chk("pre_rst_full", in_req_ready, 4'b0000);
        chk("pre_rst_valid", out_req_valid, 1);
        reset = 1'b1;
        q.delete();
        rr = 0;
        #1;
        chk("rst_async_valid", out_req_valid, 0);
        chk("rst_async_ready", in_req_ready, 4'b0000);
        advance();
        reset         = 1'b0;
        in_req_valid  = 4'b0110;
        out_req_ready = 1'b1;
        compare();
        chk("post_rst_grant", in_req_ready, 4'b0010);
        advance();
        in_req_valid = 4'b0000;
        compare();
        chk("post_rst_tag", out_req_tag[LOG_N-1:0], 1);
        advance();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 249) == 0);
            in_req_valid  = N'($urandom());
            out_req_ready = ($urandom_range(0, 3) != 0);
            rand_fields();
            out_rsp_valid = 1'($urandom());
            out_rsp_tag   = OTW'($urandom());
            for (int j = 0; j < DW / 32; j++) out_rsp_data[j*32 +: 32] = $urandom();
            in_rsp_ready  = N'($urandom());
            compare();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
